// File: rtl/img_pkg.sv
// Shared constants for the image bank writer: FSM states, bank indices and
// default widths.
package img_pkg;

    localparam int RAM_AW_DEF = 17;
    localparam int DIM_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } img_state_t;

    // Bank index is {y[0], x[0]}: E = even, O = odd, row parity first.
    localparam logic [1:0] BANK_EE = 2'd0;
    localparam logic [1:0] BANK_EO = 2'd1;
    localparam logic [1:0] BANK_OE = 2'd2;
    localparam logic [1:0] BANK_OO = 2'd3;

endpackage

// File: rtl/img_bank_addr_gen.sv
// Raster position tracker: holds x, y and the bank row base, and decodes the
// bank, address and row/frame-end flags for the beat currently presented.
module img_bank_addr_gen import img_pkg::*; #(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_adv,
    input  logic              i_sof,
    input  logic              i_last,
    input  logic [DIM_W-1:0]  i_w,
    input  logic [DIM_W-1:0]  i_h,
    output logic [1:0]        o_bank,
    output logic [RAM_AW-1:0] o_addr,
    output logic              o_row_end,
    output logic              o_len_err,
    output logic              o_frame_end,
    output logic              o_origin
);

    logic [DIM_W-1:0]  r_x, r_y;
    logic [RAM_AW-1:0] r_row_base;
    logic [DIM_W-1:0]  w_ex, w_ey;
    logic [RAM_AW-1:0] w_erb, w_hw;
    logic [DIM_W:0]    w_hw_full;
    logic              w_xmax;

    // A start-of-frame beat is always treated as pixel (0,0).
    assign w_ex      = i_sof ? '0 : r_x;
    assign w_ey      = i_sof ? '0 : r_y;
    assign w_erb     = i_sof ? '0 : r_row_base;

    assign w_hw_full = ({1'b0, i_w} + (DIM_W+1)'(1)) >> 1;
    assign w_hw      = RAM_AW'(w_hw_full);
    assign w_xmax    = (w_ex == i_w - DIM_W'(1));

    assign o_bank      = {w_ey[0], w_ex[0]};
    assign o_addr      = w_erb + RAM_AW'(w_ex >> 1);
    assign o_row_end   = w_xmax || i_last;
    assign o_len_err   = w_xmax != i_last;
    assign o_frame_end = o_row_end && (w_ey == i_h - DIM_W'(1));
    assign o_origin    = (r_x == '0) && (r_y == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
        end else if (i_clr) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
        end else if (i_adv) begin
            if (o_row_end) begin
                r_x        <= '0;
                r_y        <= w_ey + DIM_W'(1);
                r_row_base <= w_ey[0] ? w_erb + w_hw : w_erb;
            end else begin
                r_x        <= w_ex + DIM_W'(1);
                r_y        <= w_ey;
                r_row_base <= w_erb;
            end
        end
    end

endmodule

// File: rtl/img_bank_writer.sv
// Raster pixel stream to 4-bank 2x2 interleaved RAM writer, publishing the
// count of completed rows for the downstream bilinear reader.
module img_bank_writer import img_pkg::*; #(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       img0x,
    input  logic [31:0]       img0y,
    input  logic [7:0]        s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic              wea1, wea2, wea3, wea4,
    output logic              ena1, ena2, ena3, ena4,
    output logic [RAM_AW-1:0] AA1, AA2, AA3, AA4,
    output logic [7:0]        DA1, DA2, DA3, DA4,
    output logic [31:0]       row_signal,
    output logic              frame_done,
    output logic              err_len
);

    img_state_t              r_state;
    logic                    r_tready;
    logic [DIM_W-1:0]        r_w, r_h;
    logic [3:0]              r_we;
    logic [3:0][RAM_AW-1:0]  r_aa;
    logic [3:0][7:0]         r_da;
    logic [31:0]             r_rows;
    logic                    r_row_end_q, r_frame_done, r_err;

    logic                    w_wr, w_restart;
    logic [1:0]              w_bank;
    logic [RAM_AW-1:0]       w_addr;
    logic                    w_row_end, w_len_err, w_frame_end, w_origin;
    logic                    w_unused;

    assign w_unused = ^{img0x[31:DIM_W], img0y[31:DIM_W], r_state};

    // s_tready is only high in ARM/RECV; in ARM only SOF beats are written.
    assign w_wr      = s_tvalid && r_tready && !start && ((r_state == RECV) || s_tuser);
    assign w_restart = w_wr && (r_state == RECV) && s_tuser && !w_origin;

    img_bank_addr_gen #(.RAM_AW(RAM_AW), .DIM_W(DIM_W)) u_addr (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (start),
        .i_adv       (w_wr),
        .i_sof       (s_tuser),
        .i_last      (s_tlast),
        .i_w         (r_w),
        .i_h         (r_h),
        .o_bank      (w_bank),
        .o_addr      (w_addr),
        .o_row_end   (w_row_end),
        .o_len_err   (w_len_err),
        .o_frame_end (w_frame_end),
        .o_origin    (w_origin)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_tready <= 1'b0;
            r_w      <= '0;
            r_h      <= '0;
            r_err    <= 1'b0;
        end else if (start) begin
            r_state  <= ARM;
            r_tready <= 1'b1;
            r_w      <= img0x[DIM_W-1:0];
            r_h      <= img0y[DIM_W-1:0];
            r_err    <= 1'b0;
        end else if (w_wr) begin
            if (w_len_err || w_restart)
                r_err <= 1'b1;
            if (w_frame_end) begin
                r_state  <= DONE;
                r_tready <= 1'b0;
            end else begin
                r_state  <= RECV;
            end
        end
    end

    // Unselected banks keep their last address/data; only the strobe drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we <= '0;
            r_aa <= '0;
            r_da <= '0;
        end else begin
            r_we <= '0;
            if (w_wr) begin
                r_we[w_bank] <= 1'b1;
                r_aa[w_bank] <= w_addr;
                r_da[w_bank] <= s_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows       <= '0;
            r_row_end_q  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_row_end_q  <= w_wr && w_row_end;
            r_frame_done <= 1'b0;
            if (start || w_restart) begin
                r_rows <= '0;
            end else if (r_row_end_q) begin
                r_rows       <= r_rows + 32'd1;
                r_frame_done <= (r_rows + 32'd1) == {{(32-DIM_W){1'b0}}, r_h};
            end
        end
    end

    assign s_tready   = r_tready;
    assign wea1       = r_we[BANK_EE];
    assign wea2       = r_we[BANK_EO];
    assign wea3       = r_we[BANK_OE];
    assign wea4       = r_we[BANK_OO];
    assign ena1       = r_we[BANK_EE];
    assign ena2       = r_we[BANK_EO];
    assign ena3       = r_we[BANK_OE];
    assign ena4       = r_we[BANK_OO];
    assign AA1        = r_aa[BANK_EE];
    assign AA2        = r_aa[BANK_EO];
    assign AA3        = r_aa[BANK_OE];
    assign AA4        = r_aa[BANK_OO];
    assign DA1        = r_da[BANK_EE];
    assign DA2        = r_da[BANK_EO];
    assign DA3        = r_da[BANK_OE];
    assign DA4        = r_da[BANK_OO];
    assign row_signal = r_rows;
    assign frame_done = r_frame_done;
    assign err_len    = r_err;

endmodule

// File: tb/tb_img_bank_writer.sv
// Randomized bench for img_bank_writer against a pixel-coordinate reference
// model: bank = 2*(y%2) + x%2, address = (y/2)*ceil(W/2) + x/2.
module tb_img_bank_writer;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [31:0] img0x = '0, img0y = '0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic        s_tready;
    logic        wea1, wea2, wea3, wea4, ena1, ena2, ena3, ena4;
    logic [16:0] AA1, AA2, AA3, AA4;
    logic [7:0]  DA1, DA2, DA3, DA4;
    logic [31:0] row_signal;
    logic        frame_done, err_len;

    img_bank_writer dut (
        .clk(clk), .rst(rst), .start(start), .img0x(img0x), .img0y(img0y),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
        .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
        .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
        .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
        .row_signal(row_signal), .frame_done(frame_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // reference model state
    int          ph, mW, mH, mx, my, m_rows;
    logic [3:0]  m_we;
    logic [16:0] m_aa [4];
    logic [7:0]  m_da [4];
    bit          m_fd, m_err, m_pend;
    int          fd_cnt = 0, wr_cnt = 0;

    logic [3:0] d_we, d_en;
    assign d_we = {wea4, wea3, wea2, wea1};
    assign d_en = {ena4, ena3, ena2, ena1};

    task automatic model_step();
        bit acc, rend, n_fd, n_pend;
        int b, n_rows;
        logic [3:0] n_we;
        acc    = s_tvalid && (ph == 1 || ph == 2);
        n_we   = '0;
        n_pend = 0;
        n_rows = m_rows + (m_pend ? 1 : 0);
        n_fd   = m_pend && (m_rows + 1 == mH);
        if (start) begin
            mW = img0x; mH = img0y; mx = 0; my = 0; ph = 1; m_err = 0;
            n_rows = 0; n_fd = 0;
        end else if (acc && (ph == 2 || s_tuser)) begin
            if (s_tuser && ph == 2 && (mx != 0 || my != 0)) begin
                m_err = 1; mx = 0; my = 0; n_rows = 0; n_fd = 0;
            end
            b = (my % 2) * 2 + (mx % 2);
            n_we[b] = 1'b1;
            m_aa[b] = 17'((my / 2) * ((mW + 1) / 2) + mx / 2);
            m_da[b] = s_tdata;
            rend = (mx == mW - 1) || s_tlast;
            if (s_tlast != (mx == mW - 1)) m_err = 1;
            ph = 2;
            if (rend) begin
                mx = 0; my++; n_pend = 1;
                if (my == mH) ph = 3;
            end else begin
                mx++;
            end
        end
        m_we = n_we; m_rows = n_rows; m_fd = n_fd; m_pend = n_pend;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ph = 0; mx = 0; my = 0; m_rows = 0; m_we = '0;
            m_fd = 0; m_err = 0; m_pend = 0;
            for (int i = 0; i < 4; i++) begin m_aa[i] = '0; m_da[i] = '0; end
        end
        chk("tready", s_tready, (ph == 1 || ph == 2));
        chk("wea", d_we, m_we);
        chk("ena", d_en, m_we);
        chk("aa1", AA1, m_aa[0]); chk("aa2", AA2, m_aa[1]);
        chk("aa3", AA3, m_aa[2]); chk("aa4", AA4, m_aa[3]);
        chk("da1", DA1, m_da[0]); chk("da2", DA2, m_da[1]);
        chk("da3", DA3, m_da[2]); chk("da4", DA4, m_da[3]);
        chk("rows", row_signal, m_rows);
        chk("fdone", frame_done, m_fd);
        chk("err", err_len, m_err);
        fd_cnt += frame_done;
        wr_cnt += $countones(d_we);
        if (rst) model_step();
    end

    typedef struct { logic [7:0] d; logic u; logic l; } beat_t;
    beat_t q[$];

    function automatic void push(input int d, input bit u, input bit l);
        beat_t bt;
        bt.d = 8'(d); bt.u = u; bt.l = l;
        q.push_back(bt);
    endfunction

    function automatic void build(input int w, input int h, input int junk);
        q.delete();
        for (int j = 0; j < junk; j++) push($urandom, 0, 0);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) push($urandom, x == 0 && y == 0, x == w - 1);
    endfunction

    // called at posedge+1; returns at posedge+1
    task automatic send(input int gap, input bit alt);
        int idx = 0, cyc = 0;
        bit acc;
        while (idx < q.size() && cyc < 2000) begin
            s_tvalid = alt ? cyc[0] : ($urandom_range(99) >= gap);
            s_tdata  = q[idx].d; s_tuser = q[idx].u; s_tlast = q[idx].l;
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        s_tvalid = 0; s_tuser = 0; s_tlast = 0;
        chk("send_done", idx, q.size());
    endtask

    task automatic go(input int w, input int h);
        img0x = w; img0y = h; start = 1;
        @(posedge clk); #1;
        start = 0; fd_cnt = 0; wr_cnt = 0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, h;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rows", row_signal, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_we", d_we, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("idle_tready", s_tready, 0);

        // basic 4x2 frame, back-to-back
        go(4, 2); build(4, 2, 0); send(0, 0); settle();
        chk("t1_rows", row_signal, 2); chk("t1_fd", fd_cnt, 1);
        chk("t1_err", err_len, 0);     chk("t1_wr", wr_cnt, 8);

        // odd width 5x4, leading junk beat, random gaps
        go(5, 4); build(5, 4, 1); send(30, 0); settle();
        chk("t2_rows", row_signal, 4); chk("t2_tready", s_tready, 0);
        chk("t2_aa1", AA1, 5);         chk("t2_wr", wr_cnt, 20);

        // valid toggling every other cycle
        go(4, 2); build(4, 2, 0); send(0, 1); settle();
        chk("t3_wr", wr_cnt, 8); chk("t3_rows", row_signal, 2);

        // early tlast at x=2 in row 0
        go(4, 2); q.delete();
        push(1, 1, 0); push(2, 0, 0); push(3, 0, 1);
        for (int x = 0; x < 4; x++) push(16 + x, 0, x == 3);
        send(0, 0); settle();
        chk("t4_err", err_len, 1); chk("t4_rows", row_signal, 2); chk("t4_wr", wr_cnt, 7);

        // unexpected SOF at (2,1)
        go(4, 3); q.delete();
        for (int x = 0; x < 4; x++) push(x, x == 0, x == 3);
        push(8'h20, 0, 0); push(8'h21, 0, 0);
        push(8'h5a, 1, 0);
        push(8'h31, 0, 0); push(8'h32, 0, 0); push(8'h33, 0, 1);
        for (int y = 1; y < 3; y++)
            for (int x = 0; x < 4; x++) push($urandom, 0, x == 3);
        send(0, 0); settle();
        chk("t5_err", err_len, 1); chk("t5_rows", row_signal, 3); chk("t5_fd", fd_cnt, 1);

        // async reset during row 1
        go(4, 4); build(4, 4, 0);
        while (q.size() > 6) void'(q.pop_back());
        send(0, 0);
        rst = 0; #1;
        chk("t6_we", d_we, 0);         chk("t6_rows", row_signal, 0);
        chk("t6_tready", s_tready, 0); chk("t6_aa1", AA1, 0);
        chk("t6_da2", DA2, 0);         chk("t6_err", err_len, 0);
        @(posedge clk); #1;
        rst = 1;
        settle();
        chk("t6_post_tready", s_tready, 0);

        // abort mid-frame with start
        go(6, 3); build(6, 3, 0);
        while (q.size() > 5) void'(q.pop_back());
        send(0, 0);
        go(3, 2); build(3, 2, 0); send(10, 0); settle();
        chk("abort_rows", row_signal, 2); chk("abort_fd", fd_cnt, 1);

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(2, 7); h = $urandom_range(2, 5);
            go(w, h); build(w, h, $urandom_range(0, 2)); send($urandom_range(0, 50), 0); settle();
            chk("rnd_rows", row_signal, h); chk("rnd_fd", fd_cnt, 1);
            chk("rnd_wr", wr_cnt, w * h);   chk("rnd_err", err_len, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/img_bank_writer.md
Name: img_bank_writer

Overview:
- Upstream feeder for the image-scaling top. Accepts an 8-bit raster pixel stream and writes each pixel into one of the four RAM banks (write ports wea1-4/ena1-4/AA1-4/DA1-4) using a 2x2 row/column-parity interleave, so the downstream bilinear reader gets all four neighbours in one cycle.
- Publishes row_signal, the count of fully written source rows, which the downstream interpolator uses to gate its reads.

Parameters:
- RAM_AW, 17, bank address width; must match the bank RAM.
- DIM_W, 16, width of the internal x/y counters; the used LSBs of img0x/img0y.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state clears while low.
- start  in  1  one-cycle pulse; latches img0x/img0y and arms for a new frame.
- img0x  in  32  source width in pixels; valid range 2..2^DIM_W-1.
- img0y  in  32  source height in rows; valid range 2..2^DIM_W-1.
- s_tdata  in  8  pixel.
- s_tvalid  in  1  pixel valid.
- s_tready  out  1  pixel accepted when s_tvalid && s_tready.
- s_tuser  in  1  start-of-frame; qualifies the first pixel.
- s_tlast  in  1  end-of-row; qualifies the last pixel of a row.
- wea1..wea4  out  1 each  bank write enables.
- ena1..ena4  out  1 each  bank port-A enables; equal to the matching wea.
- AA1..AA4  out  RAM_AW each  bank write addresses.
- DA1..DA4  out  8 each  bank write data.
- row_signal  out  32  rows completely written in the current frame.
- frame_done  out  1  one-cycle pulse after the last row is written.
- err_len  out  1  sticky flag: row length mismatch or unexpected SOF. Cleared by start.

Behaviour:
- Reset values: s_tready=0, all wea/ena=0, AA=0, DA=0, row_signal=0, frame_done=0, err_len=0, state=IDLE.
- States:
  - IDLE -> ARM on start.
  - ARM: s_tready=1. Beats without s_tuser are dropped. A beat with s_tuser is written as pixel (0,0), then go to RECV.
  - RECV: s_tready=1. Each accepted beat is written.
  - After row img0y-1 completes: go to DONE and pulse frame_done.
  - DONE: s_tready=0. start -> ARM.
- Latching: start in any state latches W=img0x[DIM_W-1:0] and H=img0y[DIM_W-1:0], clears x, y, row_base, row_signal and err_len, and enters ARM.
- Bank select for an accepted pixel at (x,y) is {y[0],x[0]}:
  - 00 -> bank 1.
  - 01 -> bank 2.
  - 10 -> bank 3.
  - 11 -> bank 4.
- Address = row_base + (x>>1). row_base starts at 0 and increases by HW=(W+1)>>1 after every odd row completes. No multiplier.
- Latency: a beat accepted in cycle n drives exactly one wea/ena high, with its AA/DA, in cycle n+1. Unselected banks keep wea=0; their AA/DA hold their previous values.
- Throughput: one pixel per cycle. s_tready never depends on s_tvalid.
- Row completion occurs on the beat where x==W-1 or s_tlast=1, whichever comes first.
  - That beat is still written.
  - x resets to 0 and y increments.
  - row_signal increments in cycle n+2, one cycle after the row's last write strobe.
- Length errors:
  - s_tlast with x!=W-1 sets err_len; the row ends early.
  - x==W-1 without s_tlast sets err_len; the row ends anyway.
- s_tuser in RECV on a beat with (x,y)!=(0,0):
  - Sets err_len.
  - Clears x, y, row_base and row_signal.
  - The beat is written as pixel (0,0).
- frame_done pulses in the same cycle as the final row_signal increment, when row_signal becomes H.
- start mid-frame aborts the frame. A write already in the pipeline still completes in the next cycle.
- rst low mid-frame: write strobes drop immediately (asynchronous). Nothing resumes until the next start.
- Counters: x, y and row_base are DIM_W/RAM_AW wide. Overflow of row_base beyond RAM_AW is not checked; software keeps W*H/4 within 2^RAM_AW.

Decomposition:
- Shared package img_pkg:
  - State encoding constants: IDLE, ARM, RECV, DONE.
  - Bank index constants: BANK_EE=0, BANK_EO=1, BANK_OE=2, BANK_OO=3.
  - RAM_AW default.
- One sub-module, img_bank_addr_gen: holds x, y and row_base, and outputs the bank index, address and row-end flag for the current beat. The top holds the FSM, the output register stage and row_signal.

Test Plan:
- W=4, H=2, 8 beats back-to-back with correct tuser/tlast.
  - Writes go to banks 1,2,1,2,3,4,3,4 at addresses 0,0,1,1,0,0,1,1.
  - row_signal goes 0->1->2; frame_done pulses once; err_len=0.
- W=5, H=4, full frame.
  - HW=3; pixel (4,2) lands in bank 1 at address 5.
  - After the frame, row_signal=4, and s_tready=0 in DONE.
- W=4, s_tvalid toggling every other cycle.
  - Every write is exactly 1 cycle after acceptance.
  - No duplicate or missing writes; 8 total strobes.
- W=4, s_tlast on x=2 in row 0.
  - err_len=1; row 0 ends with 3 writes.
  - The next pixel goes to bank 3, address 0.
- s_tuser at (2,1) mid-frame.
  - err_len=1; row_signal clears to 0; that pixel is written to bank 1, address 0.
- rst low during row 1 of a W=4, H=4 frame.
  - All outputs return to reset values immediately.
  - After release, s_tready stays 0 until start.
